if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS32 pipeline. It owns the program counter and drives the instruction ROM address. It captures the returned instruction into the IF/ID pipeline register. It resolves next-PC selection from sequential flow, ID-stage jumps and EX-stage branches, and honours hazard-unit stall and flush requests.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/ifid_reg.sv | 55 +++++
 rtl/if_stage.sv | 125 ++++++++++++
 tb/tb_if_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg : shared MIPS32 pipeline constants and PC-select encoding   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0004;
    localparam logic [31:0] NOP_INST           = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        HOLD   = 3'd1,
        BRANCH = 3'd2,
        JR     = 3'd3,
        JUMP   = 3'd4,
        IRQ    = 3'd5
    } pc_sel_t;

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
// +----------------------------------------------------------------------+
// | ifid_reg : IF/ID pipeline register with load, flush and hold         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] inst,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] bubble_pc_plus4,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    logic [31:0] r_inst;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // A bubble normally carries pc_plus4 = 0; an interrupt bubble keeps the
    // interrupted PC+4 so the EPC can be captured further down the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst     <= NOP_INST;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_inst     <= NOP_INST;
            r_pc_plus4 <= bubble_pc_plus4;
            r_valid    <= 1'b0;
        end else if (hold) begin
            r_inst     <= r_inst;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (load) begin
            r_inst     <= inst;
            r_pc_plus4 <= pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign ifid_inst     = r_inst;
    assign ifid_pc_plus4 = r_pc_plus4;
    assign ifid_valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// +----------------------------------------------------------------------+
// | if_stage : MIPS32 instruction fetch (PC, next-PC select, IF/ID)      |
// | Optional interrupt redirect enabled by macro IF_IRQ_EN.  Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        id_jr,
    input  logic [31:0] id_jr_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
`ifdef IF_IRQ_EN
    input  logic        irq,
    output logic        irq_taken,
`endif
    output logic [31:0] pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic [31:0] w_bubble_pc_plus4;
    logic        w_flush;
    logic        w_hold;
    pc_sel_t     w_sel;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Redirects outrank stall: the stalled instruction is younger than the
    // instruction requesting the redirect.
    always_comb begin
        w_sel = SEQ;
        if (ex_branch_taken)
            w_sel = BRANCH;
        else if (id_jr)
            w_sel = JR;
        else if (id_jump)
            w_sel = JUMP;
        else if (stall)
            w_sel = HOLD;
`ifdef IF_IRQ_EN
        else if (irq && !r_pc[31])
            w_sel = IRQ;
`endif
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        unique case (w_sel)
            BRANCH:  w_pc_next = ex_branch_target & c_align_mask;
            JR:      w_pc_next = id_jr_target & c_align_mask;
            JUMP:    w_pc_next = id_jump_target & c_align_mask;
            HOLD:    w_pc_next = r_pc;
`ifdef IF_IRQ_EN
            IRQ:     w_pc_next = EXC_VECTOR & c_align_mask;
`endif
            default: w_pc_next = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pc <= RESET_PC & c_align_mask;
        else
            r_pc <= w_pc_next;
    end

    assign w_flush = (w_sel == BRANCH) || (w_sel == JR) ||
                     (w_sel == JUMP)   || (w_sel == IRQ);
    assign w_hold  = (w_sel == HOLD);
    assign w_bubble_pc_plus4 = (w_sel == IRQ) ? w_pc_plus4 : 32'h0;

`ifdef IF_IRQ_EN
    logic r_irq_taken;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_irq_taken <= 1'b0;
        else
            r_irq_taken <= (w_sel == IRQ);
    end

    assign irq_taken = r_irq_taken;
`else
    logic w_unused_exc;
    assign w_unused_exc = ^EXC_VECTOR;
`endif

    ifid_reg u_ifid_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (1'b1),
        .flush           (w_flush),
        .hold            (w_hold),
        .inst            (imem_inst),
        .pc_plus4        (w_pc_plus4),
        .bubble_pc_plus4 (w_bubble_pc_plus4),
        .ifid_inst       (ifid_inst),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid)
    );

    assign pc        = r_pc;
    assign imem_addr = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// +----------------------------------------------------------------------+
// | tb_if_stage : directed self-checking bench for if_stage              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        stall;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        id_jr;
    logic [31:0] id_jr_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [31:0] pc;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
`ifdef IF_IRQ_EN
    logic        irq;
    logic        irq_taken;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] c_rom_key = 32'hDEAD_0000;

    // ROM model: each word is its address scrambled with a fixed key.
    assign imem_inst = imem_addr ^ c_rom_key;

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_inst        (imem_inst),
        .stall            (stall),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .id_jr            (id_jr),
        .id_jr_target     (id_jr_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
`ifdef IF_IRQ_EN
        .irq              (irq),
        .irq_taken        (irq_taken),
`endif
        .pc               (pc),
        .ifid_inst        (ifid_inst),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                             input logic [31:0] e_p4, input logic e_valid);
        check({tag, ".pc"},        pc,                      e_pc);
        check({tag, ".imem_addr"}, imem_addr,               e_pc);
        check({tag, ".inst"},      ifid_inst,               e_inst);
        check({tag, ".pc_plus4"},  ifid_pc_plus4,           e_p4);
        check({tag, ".valid"},     {31'h0, ifid_valid},     {31'h0, e_valid});
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ c_rom_key;
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        id_jump = 1'b0; id_jump_target = 32'h0;
        id_jr = 1'b0;   id_jr_target = 32'h0;
        ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
`ifdef IF_IRQ_EN
        irq = 1'b0;
`endif
        step();
        check_all("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0);
`ifdef IF_IRQ_EN
        check("reset.irq_taken", {31'h0, irq_taken}, 32'h0);
`endif

        // Free-running sequential fetch.
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_all("seq", 32'h0040_0000 + 32'(4 * k), rom(32'h0040_0000 + 32'(4 * (k - 1))),
                      32'h0040_0000 + 32'(4 * k), 1'b1);
        end

        // jr to 0x00400004, then one sequential step lands on 0x00400008.
        id_jr = 1'b1; id_jr_target = 32'h0040_0004;
        step();
        id_jr = 1'b0;
        check_all("jr", 32'h0040_0004, 32'h0, 32'h0, 1'b0);
        step();
        check_all("post_jr", 32'h0040_0008, rom(32'h0040_0004), 32'h0040_0008, 1'b1);

        // Three stalled cycles hold everything.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all("stall", 32'h0040_0008, rom(32'h0040_0004), 32'h0040_0008, 1'b1);
        end
        stall = 1'b0;
        step();
        check_all("resume", 32'h0040_000C, rom(32'h0040_0008), 32'h0040_000C, 1'b1);

        // Jump with bubble, then sequential resume from target.
        id_jump = 1'b1; id_jump_target = 32'h0040_0070;
        step();
        id_jump = 1'b0;
        check_all("jump", 32'h0040_0070, 32'h0, 32'h0, 1'b0);
        step();
        check_all("post_jump", 32'h0040_0074, rom(32'h0040_0070), 32'h0040_0074, 1'b1);

        // Branch beats jr and stall.
        ex_branch_taken = 1'b1; ex_branch_target = 32'h0040_0010;
        id_jr = 1'b1; id_jr_target = 32'h0040_0200; stall = 1'b1;
        step();
        ex_branch_taken = 1'b0; stall = 1'b0;
        check_all("branch_prio", 32'h0040_0010, 32'h0, 32'h0, 1'b0);

        // jr beats jump; misaligned target bits forced to 00.
        id_jr = 1'b1; id_jr_target = 32'h0040_0203;
        id_jump = 1'b1; id_jump_target = 32'h0040_0300;
        step();
        id_jr = 1'b0;
        check_all("jr_prio", 32'h0040_0200, 32'h0, 32'h0, 1'b0);

        // Jump overrides stall, misaligned target masked.
        id_jump = 1'b1; id_jump_target = 32'h0040_0033; stall = 1'b1;
        step();
        id_jump = 1'b0; stall = 1'b0;
        check_all("jump_stall", 32'h0040_0030, 32'h0, 32'h0, 1'b0);

        // Reset during a taken branch.
        rst_n = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 32'h0040_0500;
        step();
        ex_branch_taken = 1'b0; rst_n = 1'b1;
        check_all("reset_branch", 32'h0040_0000, 32'h0, 32'h0, 1'b0);
        step();
        check_all("post_reset", 32'h0040_0004, rom(32'h0040_0000), 32'h0040_0004, 1'b1);

        // PC wraps modulo 2^32.
        id_jr = 1'b1; id_jr_target = 32'hFFFF_FFFC;
        step();
        id_jr = 1'b0;
        check("wrap.pc_top", pc, 32'hFFFF_FFFC);
        step();
        check_all("wrap", 32'h0000_0000, rom(32'hFFFF_FFFC), 32'h0000_0000, 1'b1);

`ifdef IF_IRQ_EN
        id_jr = 1'b1; id_jr_target = 32'h0040_0024;
        step();
        id_jr = 1'b0;
        check("irq.pre_pc", pc, 32'h0040_0024);
        irq = 1'b1;
        step();
        check_all("irq", 32'h8000_0004, 32'h0, 32'h0040_0028, 1'b0);
        check("irq.taken", {31'h0, irq_taken}, 32'h1);
        step();
        irq = 1'b0;
        check("irq_kernel.pc", pc, 32'h8000_0008);
        check("irq_kernel.taken", {31'h0, irq_taken}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
